alu_seq: RTL and testbench

Multi-cycle ALU sequencer; initiator side of the 6-bit ALU command interface.
- Accepts one wide operation (NWORDS x 6 bits) over a valid/ready request port.
- Issues one ALU command per cycle, one 6-bit word at a time, chaining the carry through sc_i/sc_o.
- Assembles the wide result and aggregate flags, and returns them on a valid/ready response port.
- Sits between the datapath controller and the external combinational alu instance.

---
 rtl/alu_pkg.sv | 6 +
 rtl/alu_seq.sv | 91 +++++++++
 tb/tb_alu_seq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU word width, command encodings and sequencer states
package alu_pkg;
  localparam int ALU_W = 6;
  typedef enum logic [1:0] {ADD = 2'b00, SHR = 2'b01, NAND = 2'b10, PASS = 2'b11} alu_cmd_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;
endpackage

// File: rtl/alu_seq.sv
// alu_seq: issues a wide operation to a 6-bit combinational ALU one word per cycle
module alu_seq
  import alu_pkg::*;
#(
  parameter int NWORDS = 2,
  localparam int W = ALU_W * NWORDS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  input  logic             req_cin,
  output logic [1:0]       alu_cmd,
  output logic [ALU_W-1:0] alu_inA,
  output logic [ALU_W-1:0] alu_inB,
  output logic             alu_sc_i,
  input  logic [ALU_W-1:0] alu_rslt,
  input  logic             alu_sc_o,
  input  logic             alu_pari,
  input  logic             alu_zero,
  input  logic             alu_neq,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_rslt,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic             rsp_neq,
  output logic             rsp_pari
);
  localparam int CW = NWORDS > 1 ? $clog2(NWORDS) : 1;
  seq_state_e state, state_n;
  alu_cmd_e op;
  logic [W-1:0] a, b;
  logic [CW-1:0] cnt, idx;
  logic carry, zero, neq, pari, run, last;
  assign run = state == RUN;
  assign last = cnt == CW'(NWORDS - 1);
  // shift-through-carry walks from the MSW down so the carry enters at the top
  assign idx = op == SHR ? CW'(NWORDS - 1) - cnt : cnt;
  always_comb begin
    state_n = state == IDLE ? (req_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
              (rsp_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      op <= PASS;
      a <= '0;
      b <= '0;
      cnt <= '0;
      carry <= 1'b0;
      rsp_rslt <= '0;
      zero <= 1'b0;
      neq <= 1'b0;
      pari <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      op <= alu_cmd_e'(req_op);
      a <= req_a;
      b <= req_b;
      cnt <= '0;
      carry <= req_cin;
      zero <= 1'b1;
      neq <= 1'b0;
      pari <= 1'b0;
    end else if (run) begin
      rsp_rslt[idx*ALU_W +: ALU_W] <= alu_rslt;
      zero <= zero & alu_zero;
      neq <= neq | alu_neq;
      pari <= pari ^ alu_pari;
      carry <= alu_sc_o;
      cnt <= cnt + 1'b1;
    end
  end
  assign req_ready = state == IDLE;
  assign rsp_valid = state == DONE;
  assign alu_cmd = run ? op : PASS;
  assign alu_inA = run ? a[idx*ALU_W +: ALU_W] : '0;
  assign alu_inB = run ? b[idx*ALU_W +: ALU_W] : '0;
  assign alu_sc_i = run & ~op[1] & carry;
  assign rsp_cout = ~op[1] & carry;
  assign rsp_zero = zero;
  assign rsp_neq = neq;
  assign rsp_pari = pari;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq against a behavioural 6-bit ALU
module tb_alu_seq;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_ready, req_cin = 0;
  logic [1:0] req_op = 0;
  logic [11:0] req_a = 0, req_b = 0;
  logic [1:0] alu_cmd;
  logic [5:0] alu_inA, alu_inB, alu_rslt;
  logic alu_sc_i, alu_sc_o, alu_pari, alu_zero, alu_neq;
  logic rsp_valid, rsp_ready = 0, rsp_cout, rsp_zero, rsp_neq, rsp_pari;
  logic [11:0] rsp_rslt;
  int checks = 0, errors = 0;

  alu_seq dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .alu_cmd(alu_cmd), .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_sc_i(alu_sc_i),
    .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o), .alu_pari(alu_pari),
    .alu_zero(alu_zero), .alu_neq(alu_neq),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rslt(rsp_rslt),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_neq(rsp_neq), .rsp_pari(rsp_pari)
  );

  // stand-in for the external ALU; carry-out of NAND/PASS is driven high so masking is visible
  always_comb begin
    {alu_sc_o, alu_rslt} = 7'h40 | {1'b0, alu_inA};
    if (alu_cmd == 2'b00) {alu_sc_o, alu_rslt} = {1'b0, alu_inA} + {1'b0, alu_inB} + {6'b0, alu_sc_i};
    else if (alu_cmd == 2'b01) {alu_sc_o, alu_rslt} = {alu_inA[0], alu_sc_i, alu_inA[5:1]};
    else if (alu_cmd == 2'b10) {alu_sc_o, alu_rslt} = {1'b1, ~(alu_inA & alu_inB)};
    alu_pari = ^alu_rslt;
    alu_zero = alu_rslt == 6'd0;
    alu_neq = alu_inA != alu_inB;
  end

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [11:0] a, input logic [11:0] b, input logic cin);
    req_valid = 1; req_op = op; req_a = a; req_b = b; req_cin = cin;
    tick;
    req_valid = 0;
  endtask

  task automatic consume;
    rsp_ready = 1;
    tick;
    rsp_ready = 0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("req_ready_back", req_ready, 1);
  endtask

  initial begin
    tick;
    tick;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_cmd", alu_cmd, 2'b11);
    chk("rst_alu_ops", {alu_inA, alu_inB, alu_sc_i}, 0);
    chk("rst_rsp", {rsp_rslt, rsp_cout, rsp_zero, rsp_neq, rsp_pari}, 0);
    reset = 0;
    tick;
    // ADD with carry rippling through both words
    send(2'b00, 12'hFFF, 12'h001, 0);
    chk("add1_w0", {alu_cmd, alu_inA, alu_inB, alu_sc_i}, {2'b00, 6'h3F, 6'h01, 1'b0});
    chk("add1_req_ready", req_ready, 0);
    tick;
    chk("add1_w1", {alu_inA, alu_inB, alu_sc_i}, {6'h3F, 6'h00, 1'b1});
    chk("add1_not_yet", rsp_valid, 0);
    tick;
    chk("add1_valid", rsp_valid, 1);
    chk("add1_rsp", {rsp_rslt, rsp_cout, rsp_zero, rsp_neq, rsp_pari}, {12'h000, 4'b1110});
    chk("add1_alu_idle", {alu_cmd, alu_inA, alu_inB, alu_sc_i}, {2'b11, 13'd0});
    consume;
    // ADD where only the LSW produces a carry
    send(2'b00, 12'h03F, 12'h001, 0);
    tick;
    chk("add2_w1_sc", alu_sc_i, 1);
    tick;
    chk("add2_rsp", {rsp_valid, rsp_rslt, rsp_cout, rsp_zero, rsp_neq, rsp_pari}, {1'b1, 12'h040, 4'b0011});
    consume;
    // SHR walks MSW first
    send(2'b01, 12'h801, 12'h000, 1);
    chk("shr_w0", {alu_cmd, alu_inA, alu_sc_i}, {2'b01, 6'h20, 1'b1});
    tick;
    chk("shr_w1", {alu_inA, alu_sc_i}, {6'h01, 1'b0});
    tick;
    chk("shr_rsp", {rsp_valid, rsp_rslt, rsp_cout, rsp_pari}, {1'b1, 12'hC00, 1'b1, 1'b0});
    consume;
    // NAND ignores carry-in and reports no carry-out
    send(2'b10, 12'hFFF, 12'hFFF, 1);
    chk("nand_w0_sc", {alu_cmd, alu_sc_i}, {2'b10, 1'b0});
    tick;
    chk("nand_w1_sc", alu_sc_i, 0);
    tick;
    chk("nand_rsp", {rsp_valid, rsp_rslt, rsp_cout, rsp_zero, rsp_neq}, {1'b1, 12'h000, 3'b010});
    consume;
    // PASS response held under backpressure while a new request waits
    send(2'b11, 12'h5A5, 12'h000, 0);
    chk("pass_w0", alu_inA, 6'h25);
    tick;
    chk("pass_w1", alu_inA, 6'h16);
    tick;
    req_valid = 1; req_op = 2'b00; req_a = 12'h001; req_b = 12'h002; req_cin = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {rsp_valid, req_ready, rsp_rslt, rsp_cout, rsp_zero, rsp_neq, rsp_pari},
          {2'b10, 12'h5A5, 4'b0010});
      tick;
    end
    rsp_ready = 1;
    tick;
    rsp_ready = 0;
    chk("bp_release", {rsp_valid, req_ready}, 2'b01);
    tick;
    req_valid = 0;
    chk("bp_next_accept", {req_ready, alu_cmd, alu_inA, alu_inB}, {1'b0, 2'b00, 6'h01, 6'h02});
    tick;
    tick;
    chk("bp_next_rsp", {rsp_valid, rsp_rslt, rsp_cout, rsp_zero, rsp_neq, rsp_pari}, {1'b1, 12'h003, 4'b0010});
    consume;
    // reset during the first RUN cycle discards the operation
    send(2'b00, 12'h111, 12'h222, 0);
    chk("abort_in_run", alu_cmd, 2'b00);
    reset = 1;
    tick;
    reset = 0;
    chk("abort_idle", {req_ready, rsp_valid, alu_cmd}, {1'b1, 1'b0, 2'b11});
    rsp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("abort_no_rsp", rsp_valid, 0);
    end
    rsp_ready = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
